melody_memory_game: RTL and testbench



---
 rtl/melody_memory_game.sv | 200 ++++++++++++++++++++
 tb/tb_melody_memory_game.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/melody_memory_game.sv
// Melody-repeat game core: plays a growing prefix of a loaded note sequence,
// then scores the player's keypad repeat with lives, timeout and win/lose result.
module melody_memory_game #(
  parameter int unsigned NOTE_W        = 3,
  parameter int unsigned MAX_LEN       = 8,
  parameter int unsigned START_LEN     = 3,
  parameter int unsigned TICK_DIV      = 5000000,
  parameter int unsigned ON_TICKS      = 1,
  parameter int unsigned OFF_TICKS     = 2,
  parameter int unsigned ECHO_TICKS    = 1,
  parameter int unsigned TIMEOUT_TICKS = 20,
  parameter int unsigned MAX_MISSES    = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [MAX_LEN*NOTE_W-1:0]    data_in,
  input  logic                         write_enable,
  input  logic                         game_start,
  input  logic                         key_valid,
  input  logic [NOTE_W:0]              key_code,
  output logic [NOTE_W:0]              piezo_out,
  output logic [NOTE_W:0]              led_out,
  output logic                         miss_out,
  output logic [3:0]                   lives_out,
  output logic [$clog2(MAX_LEN+1)-1:0] level_out,
  output logic                         busy,
  output logic                         game_end,
  output logic                         game_win
);

  localparam int unsigned LVL_W  = $clog2(MAX_LEN + 1);
  localparam int unsigned DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned T_A    = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int unsigned T_B    = (ECHO_TICKS > TIMEOUT_TICKS) ? ECHO_TICKS : TIMEOUT_TICKS;
  localparam int unsigned T_MAX  = (T_A > T_B) ? T_A : T_B;
  localparam int unsigned TCNT_W = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  typedef enum logic [2:0] {IDLE, PLAY_ON, PLAY_OFF, LISTEN, ECHO, WIN, LOSE} state_t;

  state_t                      state_q, state_d;
  logic [DIV_W-1:0]            div_q, div_d;
  logic [TCNT_W-1:0]           tcnt_q, tcnt_d;
  logic [MAX_LEN*NOTE_W-1:0]   seq_q, seq_d;
  logic                        loaded_q, loaded_d;
  logic [LVL_W-1:0]            idx_q, idx_d, pos_q, pos_d, level_q, level_d;
  logic [3:0]                  lives_q, lives_d;
  logic [NOTE_W:0]             piezo_q, piezo_d;
  logic                        miss_q, miss_d, hit_q, hit_d;
  logic                        end_q, end_d, win_q, win_d;
  logic                        tick, miss_event;
  logic [NOTE_W-1:0]           notes [2**LVL_W];

  assign tick = (div_q == DIV_W'(TICK_DIV - 1));

  // Unused slots above MAX_LEN read as 0 so any index width is safe.
  always_comb begin
    notes = '{default: '0};
    for (int unsigned i = 0; i < MAX_LEN; i++) notes[i] = seq_q[i*NOTE_W +: NOTE_W];
  end

  always_comb begin
    state_d    = state_q;
    div_d      = tick ? '0 : div_q + 1'b1;
    tcnt_d     = tick ? tcnt_q + 1'b1 : tcnt_q;
    seq_d      = seq_q;
    loaded_d   = loaded_q;
    idx_d      = idx_q;
    pos_d      = pos_q;
    level_d    = level_q;
    lives_d    = lives_q;
    piezo_d    = piezo_q;
    miss_d     = 1'b0;
    hit_d      = hit_q;
    end_d      = end_q;
    win_d      = win_q;
    miss_event = 1'b0;

    if (write_enable && !(state_q inside {PLAY_ON, PLAY_OFF, ECHO})) begin
      seq_d    = data_in;
      loaded_d = 1'b1;
    end

    case (state_q)
      IDLE: if (game_start && loaded_q) begin
        state_d = PLAY_ON;
        idx_d   = '0;
        lives_d = 4'(MAX_MISSES);
        level_d = LVL_W'(START_LEN);
        end_d   = 1'b0;
        win_d   = 1'b0;
      end
      PLAY_ON: if (tick && tcnt_q == TCNT_W'(ON_TICKS - 1)) begin
        state_d = PLAY_OFF;
        piezo_d = '0;
      end
      PLAY_OFF: if (tick && tcnt_q == TCNT_W'(OFF_TICKS - 1)) begin
        if (idx_q == level_q - 1'b1) begin
          state_d = LISTEN;
          pos_d   = '0;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = PLAY_ON;
        end
      end
      LISTEN: begin
        if (key_valid) begin
          state_d = ECHO;
          piezo_d = key_code;
          hit_d   = (key_code == {1'b0, notes[pos_q]} + 1'b1);
        end else if (TIMEOUT_TICKS != 0 && tick && tcnt_q == TCNT_W'(TIMEOUT_TICKS - 1)) begin
          miss_event = 1'b1;
        end
      end
      ECHO: if (tick && tcnt_q == TCNT_W'(ECHO_TICKS - 1)) begin
        piezo_d = '0;
        if (!hit_q) begin
          miss_event = 1'b1;
        end else if (pos_q != level_q - 1'b1) begin
          pos_d   = pos_q + 1'b1;
          state_d = LISTEN;
        end else if (level_q == LVL_W'(MAX_LEN)) begin
          state_d = WIN;
          end_d   = 1'b1;
          win_d   = 1'b1;
        end else begin
          level_d = level_q + 1'b1;
          idx_d   = '0;
          state_d = PLAY_ON;
        end
      end
      WIN, LOSE: if (game_start) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Timeout and wrong-key misses share one resolution path.
    if (miss_event) begin
      miss_d  = 1'b1;
      piezo_d = '0;
      lives_d = (lives_q != '0) ? lives_q - 1'b1 : '0;
      if (lives_q <= 4'd1) begin
        state_d = LOSE;
        end_d   = 1'b1;
        win_d   = 1'b0;
      end else begin
        idx_d   = '0;
        state_d = PLAY_ON;
      end
    end

    if (state_d != state_q) begin
      div_d  = '0;
      tcnt_d = '0;
    end
    if (state_d == PLAY_ON && state_q != PLAY_ON) piezo_d = {1'b0, notes[idx_d]} + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tcnt_q   <= '0;
      seq_q    <= '0;
      loaded_q <= 1'b0;
      idx_q    <= '0;
      pos_q    <= '0;
      level_q  <= LVL_W'(START_LEN);
      lives_q  <= 4'(MAX_MISSES);
      piezo_q  <= '0;
      miss_q   <= 1'b0;
      hit_q    <= 1'b0;
      end_q    <= 1'b0;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tcnt_q   <= tcnt_d;
      seq_q    <= seq_d;
      loaded_q <= loaded_d;
      idx_q    <= idx_d;
      pos_q    <= pos_d;
      level_q  <= level_d;
      lives_q  <= lives_d;
      piezo_q  <= piezo_d;
      miss_q   <= miss_d;
      hit_q    <= hit_d;
      end_q    <= end_d;
      win_q    <= win_d;
    end
  end

  assign piezo_out = piezo_q;
  assign led_out   = piezo_q;
  assign miss_out  = miss_q;
  assign lives_out = lives_q;
  assign level_out = level_q;
  assign busy      = (state_q == PLAY_ON) || (state_q == PLAY_OFF);
  assign game_end  = end_q;
  assign game_win  = win_q;

endmodule

// File: tb/tb_melody_memory_game.sv
// Directed bench for melody_memory_game: cycle table for the first level, then
// hand sequences for level growth, win, misses, lose, timeout and reset.
module tb_melody_memory_game;

  logic        clk = 1'b0;
  logic        reset, write_enable, game_start, key_valid;
  logic [11:0] data_in;
  logic [3:0]  key_code;
  logic [3:0]  piezo_out, led_out, lives_out;
  logic [2:0]  level_out;
  logic        miss_out, busy, game_end, game_win;
  logic [14:0] obs;

  int checks = 0;
  int errors = 0;

  localparam logic [11:0] SEQ = {3'd7, 3'd2, 3'd5, 3'd0};

  melody_memory_game #(
    .NOTE_W(3), .MAX_LEN(4), .START_LEN(2), .TICK_DIV(4), .ON_TICKS(1),
    .OFF_TICKS(1), .ECHO_TICKS(1), .TIMEOUT_TICKS(2), .MAX_MISSES(3)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .write_enable(write_enable),
    .game_start(game_start), .key_valid(key_valid), .key_code(key_code),
    .piezo_out(piezo_out), .led_out(led_out), .miss_out(miss_out),
    .lives_out(lives_out), .level_out(level_out), .busy(busy),
    .game_end(game_end), .game_win(game_win)
  );

  always #5 clk = ~clk;

  assign obs = {piezo_out, busy, miss_out, lives_out, level_out, game_end, game_win};

  typedef struct {
    logic        start, we, kv;
    logic [3:0]  key;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic st, input logic we, input logic kv,
                     input logic [3:0] key, input logic [3:0] pz, input logic bsy,
                     input logic ms, input logic [3:0] lv, input logic [2:0] lev,
                     input logic ge, input logic gw);
    vec_t v;
    v.start = st; v.we = we; v.kv = kv; v.key = key;
    v.exp   = {pz, bsy, ms, lv, lev, ge, gw};
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_play(input int n, input logic [15:0] notes);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++) begin
        chk("play_on", {piezo_out, busy}, {notes[i*4 +: 4], 1'b1});
        step();
      end
      for (int c = 0; c < 4; c++) begin
        chk("play_off", {piezo_out, busy}, {4'd0, 1'b1});
        step();
      end
    end
    chk("listen_entry", {piezo_out, busy}, 5'd0);
  endtask

  task automatic press(input logic [3:0] k, input logic exp_miss);
    key_valid = 1'b1;
    key_code  = k;
    step();
    key_valid = 1'b0;
    key_code  = '0;
    chk("echo", {piezo_out, led_out}, {k, k});
    repeat (4) step();
    chk("miss_after_echo", miss_out, exp_miss);
  endtask

  task automatic wait_listen();
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk("wait_listen_timeout", busy, 1'b0);
  endtask

  task automatic start_pulse();
    game_start = 1'b1;
    step();
    game_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; write_enable = 1'b0; game_start = 1'b0; key_valid = 1'b0;
    key_code = '0; data_in = SEQ;

    // First level: load, start, playback of 1,6, then keys 1,6 clear to level 3.
    add(1, 0,1,0,4'd0, 4'd0,0,0,4'd3,3'd2,0,0);
    add(1, 1,0,0,4'd0, 4'd1,1,0,4'd3,3'd2,0,0);
    add(3, 0,0,0,4'd0, 4'd1,1,0,4'd3,3'd2,0,0);
    add(4, 0,0,0,4'd0, 4'd0,1,0,4'd3,3'd2,0,0);
    add(4, 0,0,0,4'd0, 4'd6,1,0,4'd3,3'd2,0,0);
    add(4, 0,0,0,4'd0, 4'd0,1,0,4'd3,3'd2,0,0);
    add(1, 0,0,0,4'd0, 4'd0,0,0,4'd3,3'd2,0,0);
    add(1, 0,0,1,4'd1, 4'd1,0,0,4'd3,3'd2,0,0);
    add(3, 0,0,0,4'd0, 4'd1,0,0,4'd3,3'd2,0,0);
    add(1, 0,0,0,4'd0, 4'd0,0,0,4'd3,3'd2,0,0);
    add(1, 0,0,1,4'd6, 4'd6,0,0,4'd3,3'd2,0,0);
    add(3, 0,0,0,4'd0, 4'd6,0,0,4'd3,3'd2,0,0);
    add(1, 0,0,0,4'd0, 4'd1,1,0,4'd3,3'd3,0,0);

    step(); step();
    chk("reset_state", obs, {4'd0, 1'b0, 1'b0, 4'd3, 3'd2, 1'b0, 1'b0});
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      game_start = vecs[i].start; write_enable = vecs[i].we;
      key_valid = vecs[i].kv; key_code = vecs[i].key;
      step();
      game_start = 1'b0; write_enable = 1'b0; key_valid = 1'b0; key_code = '0;
      chk($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Level 3 then level 4 to a win.
    check_play(3, 16'h0361);
    press(4'd1, 1'b0); press(4'd6, 1'b0); press(4'd3, 1'b0);
    chk("level4_entry", {level_out, busy, piezo_out}, {3'd4, 1'b1, 4'd1});
    check_play(4, 16'h8361);
    press(4'd1, 1'b0); press(4'd6, 1'b0); press(4'd3, 1'b0); press(4'd8, 1'b0);
    chk("win", {game_end, game_win, busy, piezo_out, level_out}, {1'b1, 1'b1, 1'b0, 4'd0, 3'd4});

    start_pulse();
    start_pulse();
    chk("restart_after_win", obs, {4'd1, 1'b1, 1'b0, 4'd3, 3'd2, 1'b0, 1'b0});

    // Wrong key at level 2: one miss pulse, replay from the first note.
    check_play(2, 16'h0061);
    press(4'd4, 1'b1);
    chk("miss1_state", {lives_out, level_out, busy, piezo_out}, {4'd3 - 4'd1, 3'd2, 1'b1, 4'd1});
    step();
    chk("miss_one_cycle", miss_out, 1'b0);

    // Key 0 and an out-of-range key both count as misses; third miss loses.
    wait_listen();
    press(4'd0, 1'b1);
    chk("miss2_lives", lives_out, 4'd1);
    wait_listen();
    press(4'd9, 1'b1);
    chk("lose", {lives_out, game_end, game_win, busy, piezo_out}, {4'd0, 1'b1, 1'b0, 1'b0, 4'd0});
    step();
    chk("lose_no_underflow", {lives_out, miss_out}, {4'd0, 1'b0});
    start_pulse();
    start_pulse();
    chk("restart_after_lose", obs, {4'd1, 1'b1, 1'b0, 4'd3, 3'd2, 1'b0, 1'b0});

    // Timeout: no key for 8 cycles in LISTEN is a miss.
    wait_listen();
    begin
      logic early = 1'b0;
      repeat (7) begin
        step();
        early |= miss_out;
      end
      chk("no_early_timeout", early, 1'b0);
    end
    step();
    chk("timeout_miss", {miss_out, lives_out, busy}, {1'b1, 4'd2, 1'b1});

    // Key on the expiry cycle wins over the timeout.
    wait_listen();
    repeat (7) step();
    key_valid = 1'b1; key_code = 4'd1;
    step();
    key_valid = 1'b0; key_code = '0;
    chk("key_beats_timeout", {miss_out, piezo_out, lives_out}, {1'b0, 4'd1, 4'd2});
    repeat (4) step();
    chk("key_beats_timeout_resolve", {miss_out, piezo_out, busy}, {1'b0, 4'd0, 1'b0});
    press(4'd6, 1'b0);
    chk("level3_after_timeout", {level_out, busy, piezo_out}, {3'd3, 1'b1, 4'd1});

    // Key and load during PLAY_ON are ignored.
    key_valid = 1'b1; key_code = 4'd1;
    step();
    key_valid = 1'b0; key_code = '0;
    chk("key_in_play_dropped", {miss_out, lives_out, piezo_out, busy}, {1'b0, 4'd2, 4'd1, 1'b1});
    write_enable = 1'b1; data_in = 12'hFFF;
    step();
    write_enable = 1'b0;
    repeat (6) step();
    chk("load_in_play_ignored", piezo_out, 4'd6);

    // Reset mid-play clears loaded; a bare start is then ignored.
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("reset_mid_play", obs, {4'd0, 1'b0, 1'b0, 4'd3, 3'd2, 1'b0, 1'b0});
    start_pulse();
    step();
    chk("start_unloaded_ignored", {busy, piezo_out}, {1'b0, 4'd0});
    data_in = SEQ;
    write_enable = 1'b1;
    step();
    write_enable = 1'b0;
    start_pulse();
    chk("start_after_reload", {busy, piezo_out}, {1'b1, 4'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
